// File: rtl/tempo_div.sv
// Two-stage tempo divider: a PRE_DIV prescaler feeds a runtime-loadable divisor, producing
// tick pulses, a wrapping tick count and, with TEMPO_DIV_CLKOUT_EN defined, a toggled clk_out.
module tempo_div #(
  parameter int unsigned PRE_DIV = 100,
  parameter int unsigned CNT_W   = 14,
  parameter int unsigned DEF_DIV = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] div_val,
  output logic             load_ack,
  output logic             tick,
  output logic [7:0]       tick_cnt,
  output logic             clk_out
);

  localparam logic [15:0]      PRE_LAST = 16'(PRE_DIV - 1);
  localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEF_DIV);

  logic [15:0]      pre_cnt;
  logic [CNT_W-1:0] main_cnt;
  logic [CNT_W-1:0] div_reg;
  logic             pre_end;
  logic             main_end;
  logic             tick_set;

  always_comb begin
    pre_end  = (pre_cnt == PRE_LAST);
    main_end = (main_cnt == (div_reg - CNT_W'(1)));
    // A load on the same edge wins over a pending tick.
    tick_set = en && !load && pre_end && main_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt  <= '0;
      main_cnt <= '0;
      div_reg  <= DIV_RST;
      tick     <= 1'b0;
      load_ack <= 1'b0;
      tick_cnt <= '0;
    end else begin
      tick     <= tick_set;
      load_ack <= load;
      if (tick_set)
        tick_cnt <= tick_cnt + 8'd1;
      if (load) begin
        div_reg  <= (div_val == '0) ? CNT_W'(1) : div_val;
        pre_cnt  <= '0;
        main_cnt <= '0;
      end else if (en) begin
        if (pre_end) begin
          pre_cnt  <= '0;
          main_cnt <= main_end ? '0 : main_cnt + CNT_W'(1);
        end else begin
          pre_cnt <= pre_cnt + 16'd1;
        end
      end
    end
  end

`ifdef TEMPO_DIV_CLKOUT_EN
  logic clk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      clk_q <= 1'b0;
    else if (tick_set)
      clk_q <= ~clk_q;
  end

  assign clk_out = clk_q;
`else
  assign clk_out = 1'b0;
`endif

endmodule

// File: doc/tempo_div.md
TEMPO_DIV -- requirements
Module: tempo_div

Interface
REQ-001 Parameter: PRE_DIV, default 100, prescaler ratio in clk cycles, legal range 2..65535.
REQ-002 Parameter: CNT_W, default 14, width of main counter and divisor.
REQ-003 Parameter: DEF_DIV, default 100, divisor value loaded at reset, legal range 1..2^CNT_W-1.
REQ-004 clk  input  1  system clock, rising-edge active.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  count enable; low freezes both counters.
REQ-007 load  input  1  single-cycle request to load div_val.
REQ-008 div_val  input  CNT_W  new divisor, sampled when load=1.
REQ-009 load_ack  output  1  one-cycle pulse confirming a load.
REQ-010 tick  output  1  one-cycle pulse per PRE_DIV*divisor enabled clocks.
REQ-011 tick_cnt  output  8  wrapping count of ticks issued.
REQ-012 clk_out  output  1  square wave toggling on every tick (see Configuration).

Function
REQ-013 The block SHALL hold internal pre_cnt (16 bit), main_cnt (CNT_W) and div_reg (CNT_W).
REQ-014 With en=1 and load=0, pre_cnt SHALL increment each edge, wrapping PRE_DIV-1 -> 0.
REQ-015 main_cnt SHALL advance only on edges where pre_cnt==PRE_DIV-1, wrapping div_reg-1 -> 0.
REQ-016 tick SHALL be registered: 1 in the cycle after an edge with en=1, pre_cnt==PRE_DIV-1 and main_cnt==div_reg-1; 0 otherwise.
REQ-017 Tick period SHALL be exactly PRE_DIV*div_reg clk cycles under continuous en=1.
REQ-018 With en=0, pre_cnt and main_cnt SHALL hold their values and tick SHALL be 0; counting resumes from the held state.
REQ-019 On an edge with load=1, div_reg SHALL take div_val; a div_val of 0 SHALL load as 1.
REQ-020 The same edge SHALL clear pre_cnt and main_cnt, so the next tick occurs PRE_DIV*new_div enabled cycles later.
REQ-021 load_ack SHALL be 1 for exactly the cycle after each load edge, including back-to-back loads.
REQ-022 load SHALL take priority over en and over a coincident tick condition; no tick is issued on that edge.
REQ-023 A load SHALL be accepted regardless of en.
REQ-024 tick_cnt SHALL increment by 1 on each edge that sets tick, wrapping 255 -> 0; load SHALL not change it.
REQ-025 When div_reg==1, tick SHALL fire once every PRE_DIV enabled cycles.

Reset
REQ-026 rst_n low SHALL immediately set pre_cnt=0, main_cnt=0, div_reg=DEF_DIV, tick=0, load_ack=0, tick_cnt=0, clk_out=0.
REQ-027 Reset asserted mid-period SHALL discard partial counts; after release, the first tick SHALL follow PRE_DIV*DEF_DIV enabled cycles.

Configuration
REQ-028 Macro TEMPO_DIV_CLKOUT_EN defined: clk_out SHALL be registered and toggle on each edge that sets tick, giving a 50%-duty wave of period 2*PRE_DIV*div_reg; load SHALL not change clk_out.
REQ-029 Macro TEMPO_DIV_CLKOUT_EN undefined: clk_out SHALL be constant 0, with no toggle flop synthesised.

Verification (PRE_DIV=4, CNT_W=8, DEF_DIV=3)
REQ-030 Reset release, en=1 constant -> tick pulses every 12 cycles, first at cycle 12 after release; tick_cnt reads 1, 2, 3.
REQ-031 load=1, div_val=5 mid-period -> load_ack high next cycle; next tick 20 cycles after the load edge; period stays 20.
REQ-032 load with div_val=0 -> behaves as divisor 1; tick every 4 cycles.
REQ-033 en low for 7 cycles mid-period -> no ticks; tick interval stretches to exactly 12+7 cycles.
REQ-034 256 ticks -> tick_cnt wraps to 0; with TEMPO_DIV_CLKOUT_EN, clk_out toggles at each tick, high 12 / low 12 cycles.
REQ-035 rst_n pulsed low for 1 cycle at cycle 9 of a period -> all outputs 0 immediately; next tick 12 cycles after release.
